// File: rtl/viterbi_ber_monitor.sv
// rtl/viterbi_ber_monitor.sv - BER scoreboard realigning decoded bits against a circular reference history
module viterbi_ber_monitor #(
  parameter int AW      = 10,
  parameter int CW      = 16,
  parameter int ERR_TOL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] latency_i,
  input  logic [CW-1:0] num_bits_i,
  input  logic          en_i,
  input  logic          ref_bit_i,
  input  logic          dec_bit_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          cfg_err_o,
  output logic [CW-1:0] bit_ct_o,
  output logic [CW-1:0] err_ct_o,
  output logic [CW-1:0] first_err_o,
  output logic          err_seen_o,
  output logic [CW-1:0] max_burst_o,
  output logic          pass_o
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW:0]   TOL   = (CW+1)'(ERR_TOL);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          r_hist [DEPTH];
  logic [AW-1:0] r_wptr, r_lat, r_arm_ct;
  logic [CW-1:0] r_num, r_bit_ct, r_err_ct, r_first_err, r_burst, r_max_burst;
  logic          r_err_seen, r_cfg_err;

  logic [AW-1:0] w_rd_addr;
  logic          w_ref, w_cfg_bad, w_cmp, w_mis;
  logic [CW-1:0] w_bit_nx, w_burst_nx;

  // Read happens before the same-cycle write, so the entry is exactly L en-cycles old
  assign w_rd_addr  = r_wptr - r_lat;
  assign w_ref      = r_hist[w_rd_addr];
  assign w_cfg_bad  = (latency_i == '0) || (num_bits_i == '0);
  assign w_cmp      = (r_state == S_RUN) && en_i && !start_i;
  assign w_mis      = w_cmp && (w_ref != dec_bit_i);
  assign w_bit_nx   = r_bit_ct + 1'b1;
  assign w_burst_nx = w_mis ? ((r_burst == CMAX) ? CMAX : r_burst + 1'b1) : '0;

  always_ff @(posedge clk) begin
    if (en_i) r_hist[r_wptr] <= ref_bit_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
    end else begin
      r_state <= w_next;
      if (en_i) r_wptr <= r_wptr + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (start_i) begin
      w_next = w_cfg_bad ? S_DONE : S_ARM;
    end else if (en_i) begin
      case (r_state)
        S_ARM:   if (r_arm_ct == 1) w_next = S_RUN;
        S_RUN:   if (w_bit_nx == r_num) w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat       <= '0;
      r_num       <= '0;
      r_arm_ct    <= '0;
      r_bit_ct    <= '0;
      r_err_ct    <= '0;
      r_first_err <= '0;
      r_err_seen  <= 1'b0;
      r_burst     <= '0;
      r_max_burst <= '0;
      r_cfg_err   <= 1'b0;
    end else if (start_i) begin
      r_lat       <= latency_i;
      r_num       <= num_bits_i;
      r_arm_ct    <= latency_i;
      r_bit_ct    <= '0;
      r_err_ct    <= '0;
      r_first_err <= '0;
      r_err_seen  <= 1'b0;
      r_burst     <= '0;
      r_max_burst <= '0;
      r_cfg_err   <= w_cfg_bad;
    end else if (en_i) begin
      if (r_state == S_ARM) r_arm_ct <= r_arm_ct - 1'b1;
      if (w_cmp) begin
        r_bit_ct <= w_bit_nx;
        r_burst  <= w_burst_nx;
        if (w_burst_nx > r_max_burst) r_max_burst <= w_burst_nx;
        if (w_mis) begin
          if (r_err_ct != CMAX) r_err_ct <= r_err_ct + 1'b1;
          if (!r_err_seen) begin
            r_first_err <= r_bit_ct;
            r_err_seen  <= 1'b1;
          end
        end
      end
    end
  end

  assign busy_o      = (r_state == S_ARM) || (r_state == S_RUN);
  assign done_o      = (r_state == S_DONE);
  assign cfg_err_o   = r_cfg_err;
  assign bit_ct_o    = r_bit_ct;
  assign err_ct_o    = r_err_ct;
  assign first_err_o = r_first_err;
  assign err_seen_o  = r_err_seen;
  assign max_burst_o = r_max_burst;
  assign pass_o      = done_o && !r_cfg_err && ({1'b0, r_err_ct} <= TOL);

endmodule

// File: doc/viterbi_ber_monitor.md
Name: viterbi_ber_monitor

Overview:
- Synthesizable, parametrised bit-error-rate scoreboard for the conv-encoder/Viterbi-decoder loopback.
- Buffers the original data stream in a circular history.
- Realigns the decoded stream using a run-time programmable decoder latency, then compares a programmable number of bits.
- Reports compared/error counts, first-error index, longest error burst and a pass/fail verdict. Replaces fixed-delay, fixed-length checking in the bench and can also live on silicon beside viterbi_tx_rx.

Parameters:
AW, 10, history address width; buffer depth DEPTH = 2**AW entries of 1 bit
CW, 16, width of bit/error/burst counters and of num_bits_i
ERR_TOL, 0, maximum error count for which pass_o is asserted

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; (re)starts a measurement in any state
latency_i  in  AW  decoder latency L in enabled cycles; sampled on start_i
num_bits_i  in  CW  number of bits N to compare; sampled on start_i
en_i  in  1  stream advance; ref and decoded bits valid this cycle
ref_bit_i  in  1  original data bit (encoder input)
dec_bit_i  in  1  decoded data bit (decoder output)
busy_o  out  1  high in ARM or RUN
done_o  out  1  high in DONE, held until next start_i
cfg_err_o  out  1  latched high when start_i had L==0 or N==0
bit_ct_o  out  CW  bits compared so far
err_ct_o  out  CW  mismatches so far, saturating at 2**CW-1
first_err_o  out  CW  bit_ct value of first mismatch; valid when err_seen_o
err_seen_o  out  1  at least one mismatch in current run
max_burst_o  out  CW  longest run of consecutive mismatches, saturating
pass_o  out  1  done_o && !cfg_err_o && err_ct_o <= ERR_TOL

Behaviour:
- Reset (rst low, async): state IDLE, write pointer 0, all outputs 0. Buffer contents need no reset.
- History: on every en_i cycle, in any state, ref_bit_i is written at wptr and wptr increments mod DEPTH. Read address is (wptr - L) mod DEPTH, read before the same-cycle write. Entry read therefore equals ref_bit_i from exactly L en-cycles earlier.
- start_i (any state): capture L, N; clear bit_ct, err_ct, first_err, err_seen, burst, max_burst, cfg_err.
  - If L==0 or N==0: next state DONE with cfg_err_o=1.
  - Otherwise: next state ARM, arm counter = L.
  - start_i has priority over all other transitions. A start_i cycle is never counted or compared, even if en_i is high.
- Numbering: r_j and d_j are the ref/dec bits on the j-th en cycle after the start cycle (j from 0).
- ARM: each en_i decrements the arm counter. The en cycle that brings it to 0 moves to RUN; d_0..d_{L-1} are discarded.
- RUN: each en_i compares d_{j+L} with r_j and increments bit_ct.
  - On mismatch: err_ct += 1 (saturating); burst += 1 (saturating); if !err_seen then first_err := bit_ct (pre-increment value) and err_seen := 1.
  - On match: burst := 0.
  - max_burst := max(max_burst, updated burst) every compare.
  - When bit_ct reaches N: move to DONE.
- Cycles without en_i: no state, counter or pointer change.
- DONE: counters frozen; done_o and pass_o are registered, valid the cycle after the last compare.
- Latency: first compare happens on the (L+1)-th en cycle after start; done_o rises 1 clk after the (L+N)-th en cycle.
- L ≤ DEPTH-1 by width; L == DEPTH is unrepresentable, so no aliasing.
- Reset mid-ARM/RUN aborts immediately to IDLE with all outputs cleared.

Test Plan:
- Loopback: dec = ref delayed 37 en-cycles in bench, random data, L=37, N=256, en_i=1 → done after 293 en cycles; bit_ct=256, err_ct=0, err_seen=0, pass_o=1.
- Misaligned: same stream, L=36 → err_ct≈128 (±30), first_err_o ≤ 5, pass_o=0.
- Injected errors: L=37, N=256, dec flipped at compare indices 10, 11, 12 and 100 → err_ct=4, first_err=10, max_burst=3, pass_o=0 (ERR_TOL=0).
- Gapped enable: en_i toggles 1-0-1-0, L=5, N=20, clean → done after 25 en cycles (~50 clk); err_ct=0; bit_ct does not move on idle cycles.
- Config error and restart: start with L=0 → DONE next clk, cfg_err=1, pass=0. start_i mid-RUN with L=4, N=8 → counters clear; done after 12 further en cycles, cfg_err=0.
- Reset/saturation: CW=4 build, all-mismatch N=15 → err_ct=15, max_burst=15; assert rst low mid-RUN → all outputs 0 same cycle, IDLE.
